// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and defaults for the data-memory arbiter
package dmem_pkg;
    localparam int LANES      = 4;
    localparam int ADDR_W_DEF = 14;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CPU = 2'd1, ST_LDR = 2'd2} state_t;
    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_CPU = 2'd1, TAG_LDR = 2'd2} tag_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, loader and RAM-bank signals around the data-memory arbiter
interface dmem_arbiter_if import dmem_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
    logic              cpu_req;
    logic [LANES-1:0]  cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;
    logic              ldr_req;
    logic [LANES-1:0]  ldr_we;
    logic [31:0]       ldr_addr;
    logic [31:0]       ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [31:0]       ldr_rdata;
    logic [LANES-1:0]  ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_rd_return.sv
// dmem_rd_return: routes synchronous RAM read data back to the requester that issued the read
module dmem_rd_return import dmem_pkg::*; (
    input  logic        clk,
    input  logic        clr,
    input  tag_t        tag_d,
    input  logic [31:0] ram_rdata,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        ldr_rvalid,
    output logic [31:0] ldr_rdata
);
    tag_t        tag_q;
    logic [31:0] cpu_hold_q;
    logic [31:0] ldr_hold_q;
    // Owner of the read in flight; reset drops any read accepted alongside it
    always_ff @(posedge clk) begin
        if (clr) tag_q <= TAG_NONE;
        else     tag_q <= tag_d;
    end
    // Keep each requester's last returned word until its next read completes
    always_ff @(posedge clk) begin
        if (clr) begin
            cpu_hold_q <= '0;
            ldr_hold_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold_q <= ram_rdata;
            if (ldr_rvalid) ldr_hold_q <= ram_rdata;
        end
    end
    assign cpu_rvalid = tag_q == TAG_CPU;
    assign ldr_rvalid = tag_q == TAG_LDR;
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_hold_q;
    assign ldr_rdata  = ldr_rvalid ? ram_rdata : ldr_hold_q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU MEM stage and the loader/DMA port
// Optional loader starvation guard is enabled by defining DMEM_STARVE_GUARD_EN.
module dmem_arbiter import dmem_pkg::*; #(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int LDR_MAX_BURST = 16
`ifdef DMEM_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT  = 8
`endif
) (
    input logic           clk,
    input logic           clr,
    dmem_arbiter_if.slave bus
);
    localparam int BW = $clog2(LDR_MAX_BURST + 1);
    state_t        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          cpu_gnt, ldr_gnt, ldr_keep, force_ldr;
    tag_t          tag_d;
    logic          unused_ok;
`ifdef DMEM_STARVE_GUARD_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    logic [WW-1:0] wait_q, wait_d;
    // Loader wait cycles; a full count lends the loader one cycle ahead of the CPU
    always_ff @(posedge clk) begin
        if (clr) wait_q <= '0;
        else     wait_q <= wait_d;
    end
    assign wait_d    = ldr_gnt ? '0 : bus.ldr_req ? wait_q + WW'(1) : wait_q;
    assign force_ldr = bus.ldr_req & (wait_q == WW'(STARVE_LIMIT));
`else
    assign force_ldr = 1'b0;
`endif
    // Grant selection, next owner and loader burst count
    always_comb begin
        ldr_keep = (state_q == ST_LDR) & bus.ldr_req & (~bus.cpu_req | (burst_q < BW'(LDR_MAX_BURST)));
        ldr_gnt  = ~clr & (ldr_keep | force_ldr | (bus.ldr_req & ~bus.cpu_req));
        cpu_gnt  = ~clr & bus.cpu_req & ~ldr_gnt;
        state_d  = cpu_gnt ? ST_CPU : ldr_gnt ? ST_LDR : ST_IDLE;
        // A forced grant saturates the burst so the CPU reclaims the bus next cycle
        burst_d  = ~(ldr_gnt & bus.cpu_req) ? '0 : force_ldr ? BW'(LDR_MAX_BURST) : burst_q + BW'(1);
        tag_d    = (cpu_gnt & ~|bus.cpu_we) ? TAG_CPU : (ldr_gnt & ~|bus.ldr_we) ? TAG_LDR : TAG_NONE;
    end
    // Owner and burst registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end
    assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
    assign bus.ldr_gnt   = ldr_gnt;
    assign bus.ram_we    = cpu_gnt ? bus.cpu_we : ldr_gnt ? bus.ldr_we : '0;
    assign bus.ram_addr  = cpu_gnt ? bus.cpu_addr[ADDR_W+1:2] : ldr_gnt ? bus.ldr_addr[ADDR_W+1:2] : '0;
    assign bus.ram_wdata = cpu_gnt ? bus.cpu_wdata : ldr_gnt ? bus.ldr_wdata : '0;
    assign unused_ok     = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0],
                             bus.ldr_addr[31:ADDR_W+2], bus.ldr_addr[1:0]};
    dmem_rd_return u_rd (
        .clk        (clk),
        .clr        (clr),
        .tag_d      (tag_d),
        .ram_rdata  (bus.ram_rdata),
        .cpu_rvalid (bus.cpu_rvalid),
        .cpu_rdata  (bus.cpu_rdata),
        .ldr_rvalid (bus.ldr_rvalid),
        .ldr_rdata  (bus.ldr_rdata)
    );
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-cycle reference model of the arbiter
module tb_dmem_arbiter;
    localparam int AW    = 14;
    localparam int MAXB  = 16;
    localparam int SLIM  = 8;
`ifdef DMEM_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW)) bus ();
    dmem_arbiter #(.ADDR_W(AW), .LDR_MAX_BURST(MAXB)) dut (.clk(clk), .clr(clr), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // RAM banks: one-cycle synchronous read, per-lane write
    logic [31:0] ram [1 << AW];
    bit          ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
            bus.ram_rdata <= '0;
            ram_init      <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.ram_we[i]) ram[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
            bus.ram_rdata <= ram[bus.ram_addr];
        end
    end

    // Reference model: who owns the bus, how long the loader has run or waited, a shadow memory
    logic [31:0] shadow [1 << AW];
    int          m_owner  = 0;
    int          m_streak = 0;
    int          m_wait   = 0;
    int          m_pend   = 0;
    logic [31:0] m_pdata  = '0;
    logic [31:0] m_hold_c = '0;
    logic [31:0] m_hold_l = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always @(negedge clk) begin : model
        int          g;
        bit          forced;
        bit          rv_c, rv_l;
        logic [AW-1:0] ca, la;
        ca = bus.cpu_addr[AW+1:2];
        la = bus.ldr_addr[AW+1:2];
        g = 0;
        forced = 1'b0;
        if (!clr) begin
            if (m_owner == 2 && bus.ldr_req && (!bus.cpu_req || m_streak < MAXB)) g = 2;
            else if (GUARD && bus.ldr_req && m_wait == SLIM) begin g = 2; forced = 1'b1; end
            else if (bus.cpu_req) g = 1;
            else if (bus.ldr_req) g = 2;
        end
        rv_c = m_pend == 1;
        rv_l = m_pend == 2;
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && g != 1));
        chk("ldr_gnt", 32'(bus.ldr_gnt), 32'(g == 2));
        chk("ram_we", 32'(bus.ram_we), 32'(g == 1 ? bus.cpu_we : g == 2 ? bus.ldr_we : 4'h0));
        chk("ram_addr", 32'(bus.ram_addr), 32'(g == 1 ? ca : g == 2 ? la : '0));
        chk("ram_wdata", bus.ram_wdata, g == 1 ? bus.cpu_wdata : g == 2 ? bus.ldr_wdata : 32'h0);
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(rv_c));
        chk("ldr_rvalid", 32'(bus.ldr_rvalid), 32'(rv_l));
        chk("cpu_rdata", bus.cpu_rdata, rv_c ? m_pdata : m_hold_c);
        chk("ldr_rdata", bus.ldr_rdata, rv_l ? m_pdata : m_hold_l);
        if (clr) begin
            m_owner = 0; m_streak = 0; m_wait = 0; m_pend = 0;
            m_hold_c = '0; m_hold_l = '0;
        end else begin
            if (rv_c) m_hold_c = m_pdata;
            if (rv_l) m_hold_l = m_pdata;
            m_pend = 0;
            if (g == 1) begin
                if (bus.cpu_we == 4'h0) begin m_pend = 1; m_pdata = shadow[ca]; end
                else shadow[ca] = merge(shadow[ca], bus.cpu_we, bus.cpu_wdata);
            end else if (g == 2) begin
                if (bus.ldr_we == 4'h0) begin m_pend = 2; m_pdata = shadow[la]; end
                else shadow[la] = merge(shadow[la], bus.ldr_we, bus.ldr_wdata);
            end
            m_streak = (g == 2 && bus.cpu_req) ? (forced ? MAXB : m_streak + 1) : 0;
            m_wait   = (g == 2) ? 0 : bus.ldr_req ? m_wait + 1 : m_wait;
            m_owner  = g;
        end
    end

    task automatic cpu(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = r; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask
    task automatic ldr(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        bus.ldr_req = r; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
        // Reset with a CPU read pending: nothing may be granted
        cpu(1, 4'h0, 32'h10, 32'h0); ldr(0, 4'h0, 32'h0, 32'h0);
        cyc();
        @(negedge clk);
        chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_ldr_rvalid", 32'(bus.ldr_rvalid), 32'h0);
        cyc();
        // CPU store then load of the same word
        clr = 1'b0;
        cpu(1, 4'hF, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("st_ram_addr", 32'(bus.ram_addr), 32'd4);
        chk("st_ram_we", 32'(bus.ram_we), 32'hF);
        chk("st_stall", 32'(bus.cpu_stall), 32'h0);
        cyc();
        cpu(1, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("ld_ram_addr", 32'(bus.ram_addr), 32'd4);
        chk("ld_stall", 32'(bus.cpu_stall), 32'h0);
        cyc();
        cpu(0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("ld_rvalid", 32'(bus.cpu_rvalid), 32'h1);
        chk("ld_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        cyc();
        // Contention from IDLE: CPU wins until it drops its request
        cpu(1, 4'h0, 32'h20, 32'h0); ldr(1, 4'hF, 32'h40, 32'h11223344);
        @(negedge clk);
        chk("cont_ldr_gnt", 32'(bus.ldr_gnt), 32'h0);
        chk("cont_stall", 32'(bus.cpu_stall), 32'h0);
        cyc();
        @(negedge clk);
        chk("cont2_ldr_gnt", 32'(bus.ldr_gnt), 32'h0);
        cyc();
        cpu(0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("cont_handover", 32'(bus.ldr_gnt), 32'h1);
        cyc();
        // Burst limit: the loader keeps the bus for exactly MAXB cycles against the CPU
        cpu(1, 4'h0, 32'h40, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!(bus.ldr_gnt && bus.cpu_stall)) break;
            n++;
            cyc();
        end
        chk("burst_len", 32'(n), 32'd16);
        chk("burst_end_stall", 32'(bus.cpu_stall), 32'h0);
        chk("burst_end_gnt", 32'(bus.ldr_gnt), 32'h0);
        cyc();
        cpu(0, 4'h0, 32'h0, 32'h0); ldr(0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("burst_rdata", bus.cpu_rdata, 32'h11223344);
        cyc();
        // Byte-lane write over 0x11223344, then CPU and loader reads
        ldr(1, 4'b0100, 32'h41, 32'h00AB0000);
        cyc();
        ldr(0, 4'h0, 32'h0, 32'h0); cpu(1, 4'h0, 32'h42, 32'h0);
        cyc();
        cpu(0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lane_cpu_rdata", bus.cpu_rdata, 32'h11AB3344);
        chk("lane_ldr_rvalid", 32'(bus.ldr_rvalid), 32'h0);
        cyc();
        ldr(1, 4'h0, 32'h40, 32'h0);
        cyc();
        ldr(0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("ldr_rdata", bus.ldr_rdata, 32'h11AB3344);
        chk("ldr_cpu_hold", bus.cpu_rdata, 32'h11AB3344);
        cyc();
        // Reset mid-read while the loader owns the bus
        ldr(1, 4'h0, 32'h40, 32'h0);
        cyc();
        clr = 1'b1; ldr(0, 4'h0, 32'h0, 32'h0); cpu(1, 4'h0, 32'h10, 32'h0);
        cyc();
        clr = 1'b0; ldr(1, 4'h0, 32'h40, 32'h0);
        @(negedge clk);
        chk("rr_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        chk("rr_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rr_ldr_rdata", bus.ldr_rdata, 32'h0);
        chk("rr_idle_cpu_wins", 32'(bus.ldr_gnt), 32'h0);
        cyc();
        // Starvation: loader only gets in via the guard, every 9th cycle
        cpu(0, 4'h0, 32'h0, 32'h0);
        cyc();
        ldr(0, 4'h0, 32'h0, 32'h0);
        cyc();
        cpu(1, 4'h0, 32'h10, 32'h0); ldr(1, 4'h0, 32'h40, 32'h0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("starve_gnt", 32'(bus.ldr_gnt), 32'(GUARD && (i % 9 == 8)));
            cyc();
        end
        cpu(0, 4'h0, 32'h0, 32'h0); ldr(0, 4'h0, 32'h0, 32'h0);
        cyc();
        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
